demux_1_4_stream: RTL
=====================

Name: demux_1_4_stream

Overview:
- Sequential 1-to-4 demultiplexer; the inverse of the team's 4:1 mux.
- Accepts one input stream with valid/ready and steers each beat to one of four registered output channels.
- Destination comes from an explicit select or an internal round-robin pointer.
- Used to fan a single producer out to four consumers with independent back-pressure.

Parameters:
- DATA_W, 8, width of data beat.
- NUM_OUT, 4, number of output channels; fixed at 4 for this revision.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_data  input  DATA_W  input beat.
- in_valid  input  1  input beat valid.
- in_sel  input  2  destination when auto_mode=0 (0→y_0 … 3→y_3).
- auto_mode  input  1  1 = destination from round-robin pointer; in_sel ignored.
- in_ready  output  1  block can accept beat this cycle.
- y_data  output  NUM_OUT*DATA_W  output beats; channel k occupies bits [k*DATA_W +: DATA_W].
- y_valid  output  NUM_OUT  per-channel valid.
- y_ready  input  NUM_OUT  per-channel consumer ready.
- rr_ptr  output  2  current round-robin pointer (observability).

Behaviour:
- One clock domain (clk); reset synchronous, active-high (rst), sampled on rising clk edge.
- Reset values:
  - y_valid = 0.
  - y_data = 0.
  - rr_ptr = 0.
  - in_ready = 1 after reset; combinational, so it follows the ready rule below.
- Destination: dst = auto_mode ? rr_ptr : in_sel.
- Per-channel one-entry slot, states EMPTY/FULL.
  - EMPTY→FULL: accept into this channel.
  - FULL→EMPTY: y_valid[k] & y_ready[k] with no new accept into k.
  - FULL→FULL: drain and accept into k in the same cycle; new data replaces old.
- in_ready = ~y_valid[dst] | y_ready[dst]. Combinational from dst, y_valid and y_ready only; never from in_valid.
- Accept = in_valid & in_ready. On accept at edge N:
  - y_data[dst] <= in_data.
  - y_valid[dst] = 1 from cycle N+1.
  - Latency is 1 cycle.
- Non-selected channels are unaffected by an accept; they drain independently each cycle.
- y_data[k] holds stable while y_valid[k]=1 and y_ready[k]=0.
- rr_ptr:
  - Increments by 1 on each accept while auto_mode=1; wraps 3→0.
  - Holds when there is no accept or when auto_mode=0.
- Switching auto_mode mid-stream: no beat is dropped or duplicated; takes effect on the same cycle's dst.
- Stall: if dst channel is FULL and its y_ready=0, in_ready=0. Other channels still drain. Auto mode does not skip a blocked channel; strict order is kept.
- Simultaneous events:
  - rst overrides accept and drain.
  - Drain and accept on the same channel in one cycle yields FULL with the new data.
- Reset mid-operation discards all held beats and clears rr_ptr on the next edge.
- Producer must hold in_data/in_sel/in_valid stable while in_valid=1 and in_ready=0. The block does not check this rule.

Optional Feature:
- Macro: DEMUX_1_4_STREAM_CNT_EN.
- When defined:
  - Adds output port beat_cnt, NUM_OUT*16 bits: one 16-bit counter per channel.
  - Counter k increments on each y_valid[k] & y_ready[k].
  - Counters wrap 0xFFFF→0 and are cleared by rst.
- When undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg: NUM_OUT=4, SEL_W=2, CNT_W=16, slot-state enum {SLOT_EMPTY, SLOT_FULL}.
- Sub-module demux_out_slot: one-entry register with load/drain, instantiated 4×.
- Top level holds dst selection, in_ready logic, rr_ptr and optional counters.

Test Plan:
- Reset/idle:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: y_valid=0000, y_data=0, rr_ptr=0, in_ready=1.
- Directed select:
  - Stimulus: auto_mode=0, y_ready=1111; send 0xA5 sel=2, then 0x3C sel=0.
  - Required: y_valid=0100 with y_data[2]=0xA5 one cycle after the first accept. Next cycle y_valid=0001 with y_data[0]=0x3C.
- Back-pressure:
  - Stimulus: y_ready[1]=0; send 0x11 then 0x22 to sel=1.
  - Required: first accepted. in_ready=0 for the second, and y_data[1] holds 0x11. Raising y_ready[1] accepts 0x22 in the same cycle, y_data[1]=0x22 the next cycle.
- Round-robin wrap:
  - Stimulus: auto_mode=1, y_ready=1111, 5 back-to-back beats 0x01..0x05.
  - Required: beats land on channels 0,1,2,3,0. rr_ptr sequence 0→1→2→3→0→1.
- Blocked round-robin and reset mid-stream:
  - Stimulus: auto_mode=1, rr_ptr=2, y_ready[2]=0, channel 2 FULL; assert rst for 1 cycle.
  - Required: in_ready=0 and rr_ptr held at 2 while blocked. After rst: y_valid=0000, rr_ptr=0.
- Counter build (DEMUX_1_4_STREAM_CNT_EN):
  - Stimulus: 3 drains on channel 3; separately, preload to 0xFFFF and perform 1 drain.
  - Required: beat_cnt[3]=3 after the 3 drains; preloaded counter wraps to 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and slot-state type for the 1:4 stream demultiplexer.
// Channel count, select width, counter width and the per-channel slot enum.
package demux_pkg;

   localparam int NUM_OUT = 4;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 16;

   typedef enum logic {
      SLOT_EMPTY,
      SLOT_FULL
   } slot_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register with load/drain for one demux channel.
// Ports: clk, rst (sync, active-high), load + load_data in, ready in,
//        valid + data out. Load in the drain cycle keeps the slot FULL.
module demux_out_slot
   import demux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   slot_state_t       state_q;
   slot_state_t       state_d;
   logic [DATA_W-1:0] data_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
         data    <= '0;
      end else begin
         state_q <= state_d;
         data    <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data;
      unique case (state_q)
         SLOT_EMPTY: begin
            if (load) state_d = SLOT_FULL;
         end
         SLOT_FULL: begin
            if (!load && ready) state_d = SLOT_EMPTY;
         end
      endcase
      if (load) data_d = load_data;
   end

   assign valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/demux_1_4_stream.sv
// 1:4 valid/ready demux: each beat goes to in_sel or the round-robin pointer.
// Ports: clk, rst, in_data/in_valid/in_sel/auto_mode/in_ready, y_data/
//        y_valid/y_ready per channel, rr_ptr. Optional beat_cnt port when
//        DEMUX_1_4_STREAM_CNT_EN is defined (16-bit drain count per channel).
module demux_1_4_stream
   import demux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_valid,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic                      auto_mode,
   output logic                      in_ready,
   output logic [NUM_OUT*DATA_W-1:0] y_data,
   output logic [NUM_OUT-1:0]        y_valid,
   input  logic [NUM_OUT-1:0]        y_ready,
`ifdef DEMUX_1_4_STREAM_CNT_EN
   output logic [NUM_OUT*CNT_W-1:0]  beat_cnt,
`endif
   output logic [SEL_W-1:0]          rr_ptr
);

   logic [SEL_W-1:0]   dst;
   logic               accept;
   logic [NUM_OUT-1:0] load;

   assign dst = auto_mode ? rr_ptr : in_sel;

   // Depends only on the target slot, never on in_valid.
   assign in_ready = ~y_valid[dst] | y_ready[dst];
   assign accept   = in_valid & in_ready;

   always_comb begin
      load = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         load[k] = accept && (dst == SEL_W'(k));
      end
   end

   // Strict order: a blocked channel stalls the pointer, never skipped.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept && auto_mode) begin
         rr_ptr <= rr_ptr + SEL_W'(1);
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
      demux_out_slot #(
         .DATA_W(DATA_W)
      ) u_slot (
         .clk      (clk),
         .rst      (rst),
         .load     (load[k]),
         .load_data(in_data),
         .ready    (y_ready[k]),
         .valid    (y_valid[k]),
         .data     (y_data[k*DATA_W +: DATA_W])
      );
   end

`ifdef DEMUX_1_4_STREAM_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
      end else begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (y_valid[k] && y_ready[k]) begin
               beat_cnt[k*CNT_W +: CNT_W] <=
                  beat_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
         end
      end
   end
`endif

endmodule
